fft_sequencer: RTL and testbench

FFT_SEQUENCER -- requirements
Module: fft_sequencer

---
 rtl/fft_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_fft_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sequencer.sv
// -----------------------------------------------------------------------------
// fft_sequencer
//
// Address and control sequencer for an in-place radix-2 FFT on a single
// N = 2^LOG2N point sample memory.
//
// A run goes through five phases:
//   1. Wait in idle for a start request.
//   2. Load N input samples into bit-reversed locations.
//   3. For each of LOG2N stages, issue N/2 butterfly operand reads.
//   4. After each stage, let the butterfly pipeline drain so the next
//      stage never reads a location that still has a write in flight.
//   5. Pulse completion, then return to idle.
//
// Ports
//   clk, n_rst              clock; asynchronous active-low reset
//   fft_start, inverse      start request (idle only); inverse mode latched at start
//   in_valid / in_ready     load handshake; in_wr_en = in_valid & in_ready
//   in_addr                 bit-reversed load address
//   stall                   holds butterfly issue for the current cycle
//   rd_en, rd_addr_a/b      butterfly operand read strobe and addresses
//   tw_index, tw_conj       twiddle ROM index and conjugate flag, valid with rd_en
//   wr_en, wr_addr_a/b      butterfly result write, rd_* delayed by BFLY_LAT cycles
//   stage_count             current stage number
//   busy, fft_done          not idle; one-cycle completion pulse
// -----------------------------------------------------------------------------
module fft_sequencer #(
   parameter int LOG2N    = 9,
   parameter int BFLY_LAT = 2
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             fft_start,
   input  logic             inverse,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             in_wr_en,
   output logic [LOG2N-1:0] in_addr,
   input  logic             stall,
   output logic             rd_en,
   output logic [LOG2N-1:0] rd_addr_a,
   output logic [LOG2N-1:0] rd_addr_b,
   output logic [LOG2N-2:0] tw_index,
   output logic             tw_conj,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr_a,
   output logic [LOG2N-1:0] wr_addr_b,
   output logic [LOG2N-1:0] stage_count,
   output logic             busy,
   output logic             fft_done
);

   localparam logic [LOG2N-1:0]    LAST_LOAD  = {LOG2N{1'b1}};
   localparam logic [LOG2N-2:0]    LAST_BFLY  = {(LOG2N-1){1'b1}};
   localparam logic [LOG2N-1:0]    LAST_STAGE = LOG2N'(LOG2N - 1);
   // Marks the pipeline slot that drives wr_en this cycle.
   localparam logic [BFLY_LAT-1:0] OLDEST     = BFLY_LAT'(1) << (BFLY_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ISSUE = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             r_state,    w_state_next;
   logic [LOG2N-1:0]   r_load_cnt, w_load_cnt_next;
   logic [LOG2N-1:0]   r_stage,    w_stage_next;
   logic [LOG2N-2:0]   r_bfly,     w_bfly_next;
   logic               r_inverse,  w_inverse_next;

   logic [BFLY_LAT-1:0] r_pipe_vld;
   logic [LOG2N-1:0]    r_pipe_a [BFLY_LAT];
   logic [LOG2N-1:0]    r_pipe_b [BFLY_LAT];

   logic [LOG2N-1:0]   w_span;
   logic [LOG2N-1:0]   w_pos_mask;
   logic [LOG2N-2:0]   w_pos;
   logic [LOG2N-1:0]   w_tw_shift;
   logic               w_more_pending;

   // ---------------------------------------------------------------- load addr
   for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
      assign in_addr[gi] = r_load_cnt[LOG2N-1-gi];
   end

   // --------------------------------------------------------- butterfly addr
   // Operand A is the butterfly index with a zero inserted at bit position
   // 'stage'; operand B is the same address with that bit set.
   assign w_span     = LOG2N'(1) << r_stage;
   assign w_pos_mask = w_span - LOG2N'(1);
   assign w_pos      = r_bfly & w_pos_mask[LOG2N-2:0];
   assign rd_addr_a  = (({1'b0, r_bfly} & ~w_pos_mask) << 1) | {1'b0, w_pos};
   assign rd_addr_b  = rd_addr_a | w_span;
   // Twiddle exponent scales with the stage: pos * N / (2 * span).
   assign w_tw_shift = LAST_STAGE - r_stage;
   assign tw_index   = w_pos << w_tw_shift;
   assign tw_conj    = r_inverse;

   // ------------------------------------------------------------- pipeline
   assign wr_en     = r_pipe_vld[BFLY_LAT-1];
   assign wr_addr_a = r_pipe_a[BFLY_LAT-1];
   assign wr_addr_b = r_pipe_b[BFLY_LAT-1];
   // Any issue still in flight behind the one writing now.
   assign w_more_pending = |(r_pipe_vld & ~OLDEST);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_pipe_vld <= '0;
         for (int i = 0; i < BFLY_LAT; i++) begin
            r_pipe_a[i] <= '0;
            r_pipe_b[i] <= '0;
         end
      end else begin
         r_pipe_vld  <= (r_pipe_vld << 1) | BFLY_LAT'(rd_en);
         r_pipe_a[0] <= rd_addr_a;
         r_pipe_b[0] <= rd_addr_b;
         for (int i = 1; i < BFLY_LAT; i++) begin
            r_pipe_a[i] <= r_pipe_a[i-1];
            r_pipe_b[i] <= r_pipe_b[i-1];
         end
      end
   end

   // --------------------------------------------------------------- status
   assign in_wr_en    = in_valid & in_ready;
   assign stage_count = r_stage;
   assign busy        = (r_state != S_IDLE);
   assign fft_done    = (r_state == S_DONE);

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state    <= S_IDLE;
         r_load_cnt <= '0;
         r_stage    <= '0;
         r_bfly     <= '0;
         r_inverse  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_load_cnt <= w_load_cnt_next;
         r_stage    <= w_stage_next;
         r_bfly     <= w_bfly_next;
         r_inverse  <= w_inverse_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_load_cnt_next = r_load_cnt;
      w_stage_next    = r_stage;
      w_bfly_next     = r_bfly;
      w_inverse_next  = r_inverse;
      in_ready        = 1'b0;
      rd_en           = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (fft_start) begin
               w_state_next    = S_LOAD;
               w_inverse_next  = inverse;
               w_load_cnt_next = '0;
               w_stage_next    = '0;
               w_bfly_next     = '0;
            end
         end
         S_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (r_load_cnt == LAST_LOAD) begin
                  w_state_next = S_ISSUE;
                  w_stage_next = '0;
                  w_bfly_next  = '0;
               end else begin
                  w_load_cnt_next = r_load_cnt + LOG2N'(1);
               end
            end
         end
         S_ISSUE: begin
            if (!stall) begin
               rd_en = 1'b1;
               if (r_bfly == LAST_BFLY) begin
                  w_state_next = S_DRAIN;
                  w_bfly_next  = '0;
               end else begin
                  w_bfly_next = r_bfly + (LOG2N-1)'(1);
               end
            end
         end
         S_DRAIN: begin
            // Leave on the cycle the stage's final result is written.
            if (wr_en && !w_more_pending) begin
               if (r_stage == LAST_STAGE) begin
                  w_state_next = S_DONE;
               end else begin
                  w_state_next = S_ISSUE;
                  w_stage_next = r_stage + LOG2N'(1);
                  w_bfly_next  = '0;
               end
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fft_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fft_sequencer
//
// Drives fft_sequencer (LOG2N=3, BFLY_LAT=2) through directed and random runs.
// A behavioural model predicts every output on every cycle:
//   - load addresses as bit-reversed counts;
//   - butterfly pairs from span/pos/grp arithmetic;
//   - writes from a timestamped queue of issued reads.
// Literal expectations pin the model to the worked examples.
// -----------------------------------------------------------------------------
module tb_fft_sequencer;

   localparam int L    = 3;
   localparam int LAT  = 2;
   localparam int N    = 1 << L;
   localparam int HALF = N / 2;

   localparam int P_IDLE  = 0;
   localparam int P_LOAD  = 1;
   localparam int P_ISSUE = 2;
   localparam int P_WAIT  = 3;
   localparam int P_DONE  = 4;

   logic         clk = 1'b0;
   logic         n_rst;
   logic         fft_start;
   logic         inverse;
   logic         in_valid;
   logic         in_ready;
   logic         in_wr_en;
   logic [L-1:0] in_addr;
   logic         stall;
   logic         rd_en;
   logic [L-1:0] rd_addr_a;
   logic [L-1:0] rd_addr_b;
   logic [L-2:0] tw_index;
   logic         tw_conj;
   logic         wr_en;
   logic [L-1:0] wr_addr_a;
   logic [L-1:0] wr_addr_b;
   logic [L-1:0] stage_count;
   logic         busy;
   logic         fft_done;

   always #5 clk = ~clk;

   fft_sequencer #(.LOG2N(L), .BFLY_LAT(LAT)) dut (
      .clk(clk), .n_rst(n_rst), .fft_start(fft_start), .inverse(inverse),
      .in_valid(in_valid), .in_ready(in_ready), .in_wr_en(in_wr_en), .in_addr(in_addr),
      .stall(stall), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .tw_index(tw_index), .tw_conj(tw_conj), .wr_en(wr_en), .wr_addr_a(wr_addr_a),
      .wr_addr_b(wr_addr_b), .stage_count(stage_count), .busy(busy), .fft_done(fft_done)
   );

   typedef struct {
      int due;
      int a;
      int b;
   } wr_t;

   int  n_checks = 0;
   int  n_errors = 0;
   int  cyc      = 0;
   int  runs     = 0;

   // model state
   int  m_phase, m_k, m_s, m_j, m_inv, m_wr_last;
   wr_t wq[$];

   // observation
   int  t_start = -1, t_issue = -1, t_done = -1;
   bit  rec_on = 1'b0;
   int  rec_in[$], rec_a[$], rec_b[$], rec_tw[$];
   int  n_conj = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   function automatic int bitrev(input int k);
      int r = 0;
      for (int i = 0; i < L; i++)
         if (((k >> i) & 1) == 1) r |= 1 << (L - 1 - i);
      return r;
   endfunction

   function automatic void bfly(input int s, input int j, output int a, output int b,
                                output int tw);
      int span = 1 << s;
      int pos  = j % span;
      int grp  = j / span;
      a  = grp * 2 * span + pos;
      b  = a + span;
      tw = (pos << (L - 1 - s)) % HALF;
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE;
      m_k = 0; m_s = 0; m_j = 0; m_inv = 0; m_wr_last = 0;
      wq.delete();
   endtask

   // Compare every DUT output against the model for the current cycle.
   task automatic check_cycle();
      int  a, b, tw;
      bit  rd_exp, wr_exp, ld_exp;
      rd_exp = (m_phase == P_ISSUE) && !stall;
      ld_exp = (m_phase == P_LOAD) && in_valid;
      wr_exp = (wq.size() > 0) && (wq[0].due == cyc);
      chk("busy",     busy,     int'(m_phase != P_IDLE));
      chk("in_ready", in_ready, int'(m_phase == P_LOAD));
      chk("in_wr_en", in_wr_en, int'(ld_exp));
      chk("fft_done", fft_done, int'(m_phase == P_DONE));
      chk("rd_en",    rd_en,    int'(rd_exp));
      chk("wr_en",    wr_en,    int'(wr_exp));
      if (ld_exp && in_wr_en) chk("in_addr", in_addr, bitrev(m_k));
      if (rd_exp && rd_en) begin
         bfly(m_s, m_j, a, b, tw);
         chk("rd_addr_a",   rd_addr_a,   a);
         chk("rd_addr_b",   rd_addr_b,   b);
         chk("tw_index",    tw_index,    tw);
         chk("tw_conj",     tw_conj,     m_inv);
         chk("stage_count", stage_count, m_s);
      end
      if (wr_exp && wr_en) begin
         chk("wr_addr_a", wr_addr_a, wq[0].a);
         chk("wr_addr_b", wr_addr_b, wq[0].b);
      end
      if (rec_on && in_wr_en) rec_in.push_back(int'(in_addr));
      if (rec_on && rd_en) begin
         rec_a.push_back(int'(rd_addr_a));
         rec_b.push_back(int'(rd_addr_b));
         rec_tw.push_back(int'(tw_index));
         if (tw_conj) n_conj++;
      end
      if (rd_en && t_issue < 0) t_issue = cyc;
      if (fft_done) begin
         if (t_done < 0) t_done = cyc;
         runs++;
         $display("fft run %0d complete at cycle %0d inverse=%0d", runs, cyc, m_inv);
      end
   endtask

   // Advance the model across the coming clock edge.
   task automatic model_update();
      int a, b, tw;
      if (!n_rst) begin
         model_reset();
         return;
      end
      if (wq.size() > 0 && wq[0].due == cyc) void'(wq.pop_front());
      case (m_phase)
         P_IDLE: if (fft_start) begin
            m_phase = P_LOAD; m_k = 0; m_inv = int'(inverse);
            t_start = cyc; t_issue = -1; t_done = -1;
         end
         P_LOAD: if (in_valid) begin
            m_k++;
            if (m_k == N) begin m_phase = P_ISSUE; m_s = 0; m_j = 0; end
         end
         P_ISSUE: if (!stall) begin
            bfly(m_s, m_j, a, b, tw);
            wq.push_back('{cyc + LAT, a, b});
            m_j++;
            if (m_j == HALF) begin m_phase = P_WAIT; m_wr_last = cyc + LAT; end
         end
         P_WAIT: if (cyc == m_wr_last) begin
            if (m_s == L - 1) m_phase = P_DONE;
            else begin m_s++; m_j = 0; m_phase = P_ISSUE; end
         end
         default: m_phase = P_IDLE;
      endcase
   endtask

   task automatic step(input bit st, input bit inv, input bit vld, input bit stl);
      fft_start = st; inverse = inv; in_valid = vld; stall = stl;
      #1;
      check_cycle();
      model_update();
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_in[8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
      int exp_a[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
      int exp_b[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
      int exp_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
      int vpat[10]   = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
      int idx, stall_cnt, runs_before;
      bit stl, hit;

      n_rst = 1'b0; fft_start = 1'b0; inverse = 1'b0; in_valid = 1'b0; stall = 1'b0;
      model_reset();
      @(negedge clk);
      #1;
      chk("reset_busy",     busy,        0);
      chk("reset_rd_en",    rd_en,       0);
      chk("reset_wr_en",    wr_en,       0);
      chk("reset_in_ready", in_ready,    0);
      chk("reset_done",     fft_done,    0);
      chk("reset_stage",    stage_count, 0);
      chk("reset_tw_conj",  tw_conj,     0);
      chk("reset_no_x", int'($isunknown({in_addr, rd_addr_a, rd_addr_b, tw_index,
                                         wr_addr_a, wr_addr_b})), 0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n_rst = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // Run A: no stalls, in_valid held.
      rec_on = 1'b1;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 200 && t_done < 0; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
      rec_on = 1'b0;
      chk("runA_completed",      int'(t_done >= 0), 1);
      chk("runA_issue_to_done",  t_done - t_issue, 18);
      chk("runA_start_to_done",  t_done - t_start, 27);
      chk("runA_busy_after_done", busy, 0);
      chk("runA_load_count",     rec_in.size(), 8);
      chk("runA_issue_count",    rec_a.size(), 12);
      for (int i = 0; i < 8 && i < rec_in.size(); i++) chk("runA_in_addr_lit", rec_in[i], exp_in[i]);
      for (int i = 0; i < 12 && i < rec_a.size(); i++) begin
         chk("runA_rd_a_lit", rec_a[i],  exp_a[i]);
         chk("runA_rd_b_lit", rec_b[i],  exp_b[i]);
         chk("runA_tw_lit",   rec_tw[i], exp_tw[i]);
      end
      chk("runA_no_conj", n_conj, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // Run B: inverse, load gaps, stall 3 cycles mid stage 1, stall and
      // start held high where they must be ignored.
      rec_on = 1'b1; n_conj = 0; rec_a.delete();
      step(1'b1, 1'b1, 1'b0, 1'b0);
      idx = 0; stall_cnt = 0;
      for (int i = 0; i < 200 && t_done < 0; i++) begin
         if (m_phase != P_ISSUE) stl = 1'b1;
         else stl = (m_s == 1 && m_j == 2 && stall_cnt < 3);
         if (m_phase == P_ISSUE && stl) stall_cnt++;
         step(1'b1, 1'b0, (idx < 10) ? vpat[idx][0] : 1'b1, stl);
         idx++;
      end
      rec_on = 1'b0;
      chk("runB_completed",     int'(t_done >= 0), 1);
      chk("runB_issue_to_done", t_done - t_issue, 21);
      chk("runB_start_to_done", t_done - t_start, 32);
      chk("runB_conj_count",    n_conj, 12);
      chk("runB_issue_count",   rec_a.size(), 12);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // Reset pulse during stage 2.
      step(1'b1, 1'b1, 1'b0, 1'b0);
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (m_phase == P_ISSUE && m_s == 2 && m_j == 1) begin hit = 1'b1; break; end
         step(1'b0, 1'b0, 1'b1, 1'b0);
      end
      chk("rst_mid_reached", int'(hit), 1);
      n_rst = 1'b0;
      #1;
      chk("rst_mid_busy",     busy,        0);
      chk("rst_mid_rd_en",    rd_en,       0);
      chk("rst_mid_wr_en",    wr_en,       0);
      chk("rst_mid_tw_conj",  tw_conj,     0);
      chk("rst_mid_stage",    stage_count, 0);
      chk("rst_mid_in_ready", in_ready,    0);
      model_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
      n_rst = 1'b1;
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0);

      // Random traffic.
      runs_before = runs;
      for (int i = 0; i < 3000; i++)
         step(($urandom % 8) == 0, $urandom_range(0, 1) == 1,
              ($urandom % 10) < 7, ($urandom % 10) < 3);
      chk("random_runs_min", int'((runs - runs_before) >= 20), 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
